// File: rtl/mvu_pe_pipe_pkg.sv
// Shared types and width helpers for the pipelined matrix-vector PE.
package mvu_pe_pipe_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_STD     = 2'd0,
        MODE_XNOR    = 2'd1,
        MODE_BIN_ACT = 2'd2,
        MODE_BIN_WGT = 2'd3
    } mode_e;

    // Signed product of a TSrcI-bit activation and a TW-bit weight always fits here.
    function automatic int prod_width(input int src_w, input int wgt_w);
        return src_w + wgt_w;
    endfunction

    function automatic int clog2_int(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? clog2_int(n) : 1;
    endfunction

endpackage

// File: rtl/mvu_pe_lane.sv
// One SIMD lane: mode-selected product of an activation/weight pair,
// sign-extended to the accumulator width.
module mvu_pe_lane
    import mvu_pe_pipe_pkg::*;
#(
    parameter int TSrcI      = 4,
    parameter int TW         = 4,
    parameter int TDstI      = 16,
    parameter int ACT_SIGNED = 1
) (
    input  logic [TSrcI-1:0] i_act,
    input  logic [TW-1:0]    i_wgt,
    input  mode_e            i_mode,
    output logic [TDstI-1:0] o_prod
);

    localparam int PW = prod_width(TSrcI, TW);

    logic [PW-1:0] w_act_s;
    logic [PW-1:0] w_act_x;
    logic [PW-1:0] w_wgt_s;
    logic [PW-1:0] w_mul;
    logic [PW-1:0] w_res;

    assign w_act_s = {{(PW-TSrcI){i_act[TSrcI-1]}}, i_act};
    assign w_act_x = (ACT_SIGNED != 0) ? w_act_s : {{(PW-TSrcI){1'b0}}, i_act};
    assign w_wgt_s = {{(PW-TW){i_wgt[TW-1]}}, i_wgt};

    // Low PW bits of the product are exact because the true result fits in PW signed bits.
    assign w_mul = w_act_x * w_wgt_s;

    always_comb begin
        w_res = w_mul;
        case (i_mode)
            MODE_STD:     w_res = w_mul;
            MODE_XNOR:    w_res = {{(PW-1){1'b0}}, ~(i_act[0] ^ i_wgt[0])};
            MODE_BIN_ACT: w_res = i_act[0] ? w_wgt_s : (PW'(0) - w_wgt_s);
            MODE_BIN_WGT: w_res = i_wgt[0] ? w_act_s : (PW'(0) - w_act_s);
        endcase
    end

    assign o_prod = {{(TDstI-PW){w_res[PW-1]}}, w_res};

endmodule

// File: rtl/mvu_pe_pipe.sv
// Streaming matrix-vector PE: per-lane products, adder tree, per-fold
// accumulation and a valid/ready result register with full backpressure.
module mvu_pe_pipe
    import mvu_pe_pipe_pkg::*;
#(
    parameter int SIMD       = 4,
    parameter int TSrcI      = 4,
    parameter int TW         = 4,
    parameter int TDstI      = 16,
    parameter int SF         = 8,
    parameter int ACT_SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MODE_W-1:0]     mode,
    input  logic                  flush,
    input  logic                  in_v,
    output logic                  in_rdy,
    input  logic [SIMD*TSrcI-1:0] in_act,
    input  logic [SIMD*TW-1:0]    in_wgt,
    output logic                  out_v,
    input  logic                  out_rdy,
    output logic [TDstI-1:0]      out
);

    localparam int CW = cnt_width(SF);
    localparam int NL = clog2_int(SIMD);
    localparam int P  = 1 << NL;

    logic                  r_rst_done;
    logic [CW-1:0]         r_cnt;
    mode_e                 r_mode;
    logic                  r_s1_v;
    logic                  r_s1_last;
    logic [SIMD*TDstI-1:0] r_prod;
    logic                  r_s2_v;
    logic                  r_s2_last;
    logic [TDstI-1:0]      r_sum;
    logic [TDstI-1:0]      r_acc;
    logic                  r_out_v;
    logic [TDstI-1:0]      r_out;

    logic                  w_en;
    logic                  w_accept;
    logic                  w_first;
    logic                  w_last;
    mode_e                 w_mode;
    logic [SIMD*TDstI-1:0] w_prod;
    logic [TDstI-1:0]      w_tree_sum;
    logic                  w_result;

    assign w_en     = !(r_out_v && !out_rdy);
    assign in_rdy   = r_rst_done && w_en && !flush;
    assign w_accept = in_v && in_rdy;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == CW'(SF - 1));
    // The first beat of a fold uses the live mode; later beats use the latched one.
    assign w_mode   = w_first ? mode_e'(mode) : r_mode;
    assign w_result = r_s2_v && r_s2_last && !flush;

    assign out_v = r_out_v;
    assign out   = r_out;

    genvar gi, gl;
    generate
        for (gi = 0; gi < SIMD; gi++) begin : g_lane
            mvu_pe_lane #(
                .TSrcI      (TSrcI),
                .TW         (TW),
                .TDstI      (TDstI),
                .ACT_SIGNED (ACT_SIGNED)
            ) u_lane (
                .i_act  (in_act[(SIMD-1-gi)*TSrcI +: TSrcI]),
                .i_wgt  (in_wgt[(SIMD-1-gi)*TW +: TW]),
                .i_mode (w_mode),
                .o_prod (w_prod[gi*TDstI +: TDstI])
            );
        end

        // Binary adder tree over a power-of-two padded set of lanes.
        for (gl = 0; gl <= NL; gl++) begin : g_lvl
            logic [(P>>gl)*TDstI-1:0] w_node;
            for (gi = 0; gi < (P >> gl); gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    if (gi < SIMD) begin : g_used
                        assign w_node[gi*TDstI +: TDstI] = r_prod[gi*TDstI +: TDstI];
                    end else begin : g_pad
                        assign w_node[gi*TDstI +: TDstI] = '0;
                    end
                end else begin : g_add
                    assign w_node[gi*TDstI +: TDstI] =
                        g_lvl[gl-1].w_node[(2*gi)*TDstI +: TDstI] +
                        g_lvl[gl-1].w_node[(2*gi+1)*TDstI +: TDstI];
                end
            end
        end
    endgenerate

    assign w_tree_sum = g_lvl[NL].w_node[TDstI-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_cnt      <= '0;
            r_mode     <= MODE_STD;
        end else begin
            r_rst_done <= 1'b1;
            if (w_en) begin
                if (flush) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                    if (w_first) begin
                        r_mode <= mode_e'(mode);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_prod    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_last <= 1'b0;
            r_sum     <= '0;
        end else if (w_en) begin
            if (flush) begin
                r_s1_v <= 1'b0;
                r_s2_v <= 1'b0;
            end else begin
                r_s1_v <= w_accept;
                if (w_accept) begin
                    r_s1_last <= w_last;
                    r_prod    <= w_prod;
                end
                r_s2_v    <= r_s1_v;
                r_s2_last <= r_s1_last;
                r_sum     <= w_tree_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_out_v <= 1'b0;
            r_out   <= '0;
        end else if (w_en) begin
            if (flush) begin
                r_acc <= '0;
            end else if (r_s2_v) begin
                r_acc <= r_s2_last ? '0 : r_acc + r_sum;
            end
            // A new result replaces a consumed one in the same cycle without a bubble.
            if (w_result) begin
                r_out   <= r_acc + r_sum;
                r_out_v <= 1'b1;
            end else if (out_rdy) begin
                r_out_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mvu_pe_pipe.sv
// Randomized and directed bench for mvu_pe_pipe against an integer fold model.
module tb_mvu_pe_pipe;

    localparam int SIMD       = 4;
    localparam int TSrcI      = 4;
    localparam int TW         = 4;
    localparam int TDstI      = 16;
    localparam int SF         = 2;
    localparam int ACT_SIGNED = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        flush = 1'b0;
    logic        in_v = 1'b0;
    logic        in_rdy;
    logic [15:0] in_act = '0;
    logic [15:0] in_wgt = '0;
    logic        out_v;
    logic        out_rdy = 1'b1;
    logic [15:0] out;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    int          m_cnt = 0;
    int          m_mode = 0;
    int          m_acc = 0;
    logic        s_rdy;
    logic        s_ov;
    logic [15:0] s_out;

    mvu_pe_pipe #(
        .SIMD(SIMD), .TSrcI(TSrcI), .TW(TW), .TDstI(TDstI), .SF(SF), .ACT_SIGNED(ACT_SIGNED)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .flush   (flush),
        .in_v    (in_v),
        .in_rdy  (in_rdy),
        .in_act  (in_act),
        .in_wgt  (in_wgt),
        .out_v   (out_v),
        .out_rdy (out_rdy),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sum over lanes of one beat, from the mode rules with plain integers.
    function automatic int beat_sum(input int md, input logic [15:0] a, input logic [15:0] w);
        int s;
        int au;
        int av;
        int wv;
        logic [3:0] ai;
        logic [3:0] wi;
        s = 0;
        for (int i = 0; i < SIMD; i++) begin
            ai = a[(SIMD-1-i)*4 +: 4];
            wi = w[(SIMD-1-i)*4 +: 4];
            au = int'(ai);
            av = ai[3] ? au - 16 : au;
            wv = wi[3] ? int'(wi) - 16 : int'(wi);
            case (md)
                0: s += ((ACT_SIGNED != 0) ? av : au) * wv;
                1: s += (ai[0] == wi[0]) ? 1 : 0;
                2: s += ai[0] ? wv : -wv;
                default: s += wi[0] ? av : -av;
            endcase
        end
        return s;
    endfunction

    task automatic model_beat(input int md, input logic [15:0] a, input logic [15:0] w);
        if (m_cnt == 0) m_mode = md;
        m_acc += beat_sum(m_mode, a, w);
        m_cnt++;
        if (m_cnt == SF) begin
            exp_q.push_back(16'(m_acc));
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    task automatic model_clear();
        m_acc = 0;
        m_cnt = 0;
    endtask

    // One clock cycle: drive at negedge, sample #1 later, update model and scoreboard.
    task automatic cyc(input logic v, input logic [15:0] a, input logic [15:0] w,
                       input logic [1:0] md, input logic fl, input logic ordy);
        @(negedge clk);
        in_v = v; in_act = a; in_wgt = w; mode = md; flush = fl; out_rdy = ordy;
        #1;
        s_rdy = in_rdy;
        s_ov  = out_v;
        s_out = out;
        if (in_v && in_rdy) model_beat(int'(md), a, w);
        if (fl && !(out_v && !out_rdy)) model_clear();
        if (out_v && out_rdy) begin
            if (exp_q.size() == 0) check_val("extra_result", 32'(out_v), 32'd0);
            else check_val("result", 32'(out), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b1);
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp);
        bit got;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b1);
            if (s_ov) begin
                got = 1;
                check_val(tag, 32'(s_out), 32'(exp));
            end
        end
        if (!got) check_val({tag, "_timeout"}, 32'(s_ov), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        bit got;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_in_rdy", 32'(in_rdy), 32'd0);
        check_val("rst_out_v", 32'(out_v), 32'd0);
        check_val("rst_out", 32'(out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_val("rdy_after_rst", 32'(in_rdy), 32'd1);

        // Std mode fold with latency check: 10 + (-8) = 2
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'hFFFF, 16'h2222, 2'd0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b1);
        check_val("lat_c1_out_v", 32'(s_ov), 32'd0);
        cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b1);
        check_val("lat_c2_out_v", 32'(s_ov), 32'd0);
        cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, 1'b1);
        check_val("lat_c3_out_v", 32'(s_ov), 32'd1);
        check_val("std_out", 32'(s_out), 32'd2);
        idle(2);

        // Xnor: 2 per beat
        cyc(1'b1, 16'h1010, 16'h1100, 2'd1, 1'b0, 1'b1);
        cyc(1'b1, 16'h1010, 16'h1100, 2'd1, 1'b0, 1'b1);
        wait_result("xnor_out", 16'd4);
        // Binary activation: 3 - 3 - 2 + 5 = 3 per beat
        cyc(1'b1, 16'h1011, 16'h33E5, 2'd2, 1'b0, 1'b1);
        cyc(1'b1, 16'h1011, 16'h33E5, 2'd2, 1'b0, 1'b1);
        wait_result("binact_out", 16'd6);
        // Binary weight: -8 per beat
        cyc(1'b1, 16'h4444, 16'h0001, 2'd3, 1'b0, 1'b1);
        cyc(1'b1, 16'h4444, 16'h0001, 2'd3, 1'b0, 1'b1);
        wait_result("binwgt_out", 16'hFFF0);
        // Mode change mid-fold is ignored
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'h1234, 16'h1111, 2'd1, 1'b0, 1'b1);
        wait_result("mode_latch_out", 16'd20);

        // Backpressure with in_v held high
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 16'h1234, 16'h2222, 2'd0, 1'b0, 1'b0);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            got = s_ov;
        end
        if (!got) check_val("bp_wait_timeout", 32'(s_ov), 32'd1);
        held = s_out;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            check_val("bp_in_rdy", 32'(s_rdy), 32'd0);
            check_val("bp_out_v", 32'(s_ov), 32'd1);
            check_val("bp_out_hold", 32'(s_out), 32'(held));
        end

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 9) < 7));
        end
        idle(10);
        check_val("drain_empty", 32'(exp_q.size()), 32'd0);

        // Flush discards a partial fold
        cyc(1'b0, 16'h0, 16'h0, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b1);
        idle(5);
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b1, 1'b1);
        check_val("flush_in_rdy", 32'(s_rdy), 32'd0);
        cyc(1'b1, 16'h1000, 16'h1000, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'h1000, 16'h1000, 2'd0, 1'b0, 1'b1);
        wait_result("flush_out", 16'd2);

        // Asynchronous reset mid-fold
        idle(3);
        cyc(1'b1, 16'h7777, 16'h7777, 2'd0, 1'b0, 1'b1);
        idle(2);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_out_v", 32'(out_v), 32'd0);
        check_val("arst_out", 32'(out), 32'd0);
        check_val("arst_in_rdy", 32'(in_rdy), 32'd0);
        exp_q.delete();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b1);
        cyc(1'b1, 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b1);
        check_val("post_rst_rdy", 32'(s_rdy), 32'd1);
        wait_result("post_rst_out", 16'd20);
        idle(4);
        check_val("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
